// File: rtl/ls_writeback_arbiter_pkg.sv
// rtl/ls_writeback_arbiter_pkg.sv - shared widths and FIFO entry record for the LS writeback arbiter
package ls_wb_pkg;

  localparam int REG_W  = 4;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/ls_writeback_arbiter_if.sv
// rtl/ls_writeback_arbiter_if.sv - writeback request, forwarding and register-file write bundle
interface ls_writeback_arbiter_if;

  logic                         WB_EN;
  logic [ls_wb_pkg::REG_W-1:0]  WB_Addr;
  logic [ls_wb_pkg::DATA_W-1:0] WB_data;
  logic                         L_EN;
  logic [ls_wb_pkg::REG_W-1:0]  L_Addr;
  logic [ls_wb_pkg::DATA_W-1:0] L_data;
  logic                         DP_WE;
  logic [ls_wb_pkg::REG_W-1:0]  DP_Addr;
  logic [ls_wb_pkg::DATA_W-1:0] DP_data;
  logic [ls_wb_pkg::REG_W-1:0]  FWD_Addr;
  logic                         FWD_HIT;
  logic [ls_wb_pkg::DATA_W-1:0] FWD_data;
  logic                         RF_WE;
  logic [ls_wb_pkg::REG_W-1:0]  RF_WADDR;
  logic [ls_wb_pkg::DATA_W-1:0] RF_WDATA;
  logic                         STALL;
  logic                         OVF;

  modport master (
    output WB_EN, WB_Addr, WB_data, L_EN, L_Addr, L_data,
    output DP_WE, DP_Addr, DP_data, FWD_Addr,
    input  FWD_HIT, FWD_data, RF_WE, RF_WADDR, RF_WDATA, STALL, OVF
  );

  modport slave (
    input  WB_EN, WB_Addr, WB_data, L_EN, L_Addr, L_data,
    input  DP_WE, DP_Addr, DP_data, FWD_Addr,
    output FWD_HIT, FWD_data, RF_WE, RF_WADDR, RF_WDATA, STALL, OVF
  );

endinterface

// File: rtl/ls_writeback_arbiter_fifo.sv
// rtl/ls_writeback_arbiter_fifo.sv - dual-push/single-pop ring with kill-by-address and newest-first match
module ls_wb_fifo
  import ls_wb_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push0_i,
  input  wb_entry_t         push0_entry_i,
  input  logic              push1_i,
  input  wb_entry_t         push1_entry_i,
  input  logic              pop_i,
  input  logic              kill_i,
  input  logic [REG_W-1:0]  kill_addr_i,
  input  logic [REG_W-1:0]  match_addr_i,
  output logic              match_hit_o,
  output logic [DATA_W-1:0] match_data_o,
  output wb_entry_t         head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] idx;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push0_i) + PTR_W'(push1_i);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
    count_d  = count_q + CNT_W'(push0_i) + CNT_W'(push1_i) - CNT_W'(pop_i);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Kill first so a same-edge push (validity already resolved upstream) overrides it.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (kill_i && mem_q[i].addr == kill_addr_i) mem_q[i].valid <= 1'b0;
    end
    if (push0_i) mem_q[wr_ptr_q] <= push0_entry_i;
    if (push1_i) mem_q[wr_ptr_q + PTR_W'(push0_i)] <= push1_entry_i;
  end

  // Walk oldest to newest so the last hit is the newest pending value.
  always_comb begin
    match_hit_o  = 1'b0;
    match_data_o = '0;
    idx          = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PTR_W'(i);
      if (CNT_W'(i) < count_q && mem_q[idx].valid && mem_q[idx].addr == match_addr_i) begin
        match_hit_o  = 1'b1;
        match_data_o = mem_q[idx].data;
      end
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ls_writeback_arbiter.sv
// rtl/ls_writeback_arbiter.sv - merges LS and DP writebacks onto the single register-file write port
module ls_writeback_arbiter
  import ls_wb_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int SKID  = 6
) (
  input logic CLK,
  input logic RST,
  ls_writeback_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  wb_entry_t         wb_entry, l_entry, slot0_entry, head;
  logic              wb_req, l_req, slot0_req, slot1_req;
  logic              push0, push1, pop, drop;
  logic [CNT_W-1:0]  count, space;
  logic              fifo_hit;
  logic [DATA_W-1:0] fifo_data;
  logic              rf_hit;

  logic              rf_we_q, rf_we_d;
  logic [REG_W-1:0]  rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic              ovf_q, ovf_d;

  // A younger load to the same register makes the base write-back dead.
  always_comb begin
    wb_req         = bus.WB_EN && !(bus.L_EN && bus.WB_Addr == bus.L_Addr);
    l_req          = bus.L_EN;
    wb_entry.valid = !(bus.DP_WE && bus.WB_Addr == bus.DP_Addr);
    wb_entry.addr  = bus.WB_Addr;
    wb_entry.data  = bus.WB_data;
    l_entry.valid  = !(bus.DP_WE && bus.L_Addr == bus.DP_Addr);
    l_entry.addr   = bus.L_Addr;
    l_entry.data   = bus.L_data;
    slot0_req      = wb_req || l_req;
    slot1_req      = wb_req && l_req;
    slot0_entry    = wb_req ? wb_entry : l_entry;
    pop            = !bus.DP_WE && count != '0;
    space          = CNT_W'(DEPTH) - count + CNT_W'(pop);
    push0          = slot0_req && space != '0;
    push1          = slot1_req && space >= CNT_W'(2);
    drop           = (slot0_req && !push0) || (slot1_req && !push1);
  end

  ls_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i         (CLK),
    .rst_ni        (RST),
    .push0_i       (push0),
    .push0_entry_i (slot0_entry),
    .push1_i       (push1),
    .push1_entry_i (l_entry),
    .pop_i         (pop),
    .kill_i        (bus.DP_WE),
    .kill_addr_i   (bus.DP_Addr),
    .match_addr_i  (bus.FWD_Addr),
    .match_hit_o   (fifo_hit),
    .match_data_o  (fifo_data),
    .head_o        (head),
    .count_o       (count)
  );

  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    ovf_d      = ovf_q || drop;
    if (bus.DP_WE) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = bus.DP_Addr;
      rf_wdata_d = bus.DP_data;
    end else if (pop && head.valid) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = head.addr;
      rf_wdata_d = head.data;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      ovf_q      <= ovf_d;
    end
  end

  assign rf_hit       = rf_we_q && rf_waddr_q == bus.FWD_Addr;
  assign bus.FWD_HIT  = fifo_hit || rf_hit;
  assign bus.FWD_data = fifo_hit ? fifo_data : (rf_hit ? rf_wdata_q : '0);
  assign bus.RF_WE    = rf_we_q;
  assign bus.RF_WADDR = rf_waddr_q;
  assign bus.RF_WDATA = rf_wdata_q;
  assign bus.STALL    = (CNT_W'(DEPTH) - count) < CNT_W'(SKID);
  assign bus.OVF      = ovf_q;

endmodule

// File: tb/tb_ls_writeback_arbiter.sv
// tb/tb_ls_writeback_arbiter.sv - directed self-checking bench for ls_writeback_arbiter
module tb_ls_writeback_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  ls_writeback_arbiter_if bus ();

  ls_writeback_arbiter #(.DEPTH(8), .SKID(6)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.WB_EN = 1'b0; bus.WB_Addr = '0; bus.WB_data = '0;
    bus.L_EN  = 1'b0; bus.L_Addr  = '0; bus.L_data  = '0;
    bus.DP_WE = 1'b0; bus.DP_Addr = '0; bus.DP_data = '0;
  endtask

  task automatic rf(input string tag, input logic we, input logic [3:0] a, input logic [31:0] d);
    check({tag, ".we"}, 32'(bus.RF_WE), 32'(we));
    check({tag, ".addr"}, 32'(bus.RF_WADDR), 32'(a));
    check({tag, ".data"}, bus.RF_WDATA, d);
  endtask

  task automatic ls(input logic wb, input logic [3:0] wa, input logic [31:0] wd,
                    input logic l, input logic [3:0] la, input logic [31:0] ld);
    bus.WB_EN = wb; bus.WB_Addr = wa; bus.WB_data = wd;
    bus.L_EN  = l;  bus.L_Addr  = la; bus.L_data  = ld;
  endtask

  task automatic dp(input logic [3:0] a, input logic [31:0] d);
    bus.DP_WE = 1'b1; bus.DP_Addr = a; bus.DP_data = d;
  endtask

  initial begin
    idle();
    bus.FWD_Addr = 4'd3;
    step();
    step();
    rf("reset", 1'b0, 4'd0, 32'h0);
    check("reset.ovf", 32'(bus.OVF), 32'd0);
    check("reset.stall", 32'(bus.STALL), 32'd0);
    check("reset.fwd_hit", 32'(bus.FWD_HIT), 32'd0);
    rst = 1'b1;
    step();

    // single load: no cut-through, lands after the second edge
    ls(1'b0, 4'd0, 32'h0, 1'b1, 4'd3, 32'h1234);
    step();
    idle();
    #1;
    check("t1.latency_we", 32'(bus.RF_WE), 32'd0);
    check("t1.fwd_fifo_hit", 32'(bus.FWD_HIT), 32'd1);
    check("t1.fwd_fifo_data", bus.FWD_data, 32'h1234);
    step();
    rf("t1.write", 1'b1, 4'd3, 32'h1234);
    check("t1.fwd_rf_data", bus.FWD_data, 32'h1234);
    step();
    rf("t1.hold", 1'b0, 4'd3, 32'h1234);
    check("t1.fwd_gone", 32'(bus.FWD_HIT), 32'd0);

    // dual push: base first, then load
    ls(1'b1, 4'd1, 32'h100, 1'b1, 4'd2, 32'hAB);
    step();
    idle();
    step();
    rf("t2.first", 1'b1, 4'd1, 32'h100);
    step();
    rf("t2.second", 1'b1, 4'd2, 32'hAB);
    step();
    check("t2.done", 32'(bus.RF_WE), 32'd0);

    // same register: load wins, single write
    ls(1'b1, 4'd4, 32'h100, 1'b1, 4'd4, 32'hAB);
    step();
    idle();
    step();
    rf("t2.merge", 1'b1, 4'd4, 32'hAB);
    step();
    check("t2.merge_single", 32'(bus.RF_WE), 32'd0);

    // DP has priority over queued LS entries
    ls(1'b1, 4'd8, 32'h800, 1'b1, 4'd9, 32'h900);
    step();
    idle();
    for (int k = 0; k < 3; k++) begin
      dp(4'd10, 32'hD0 + 32'(k));
      step();
      rf($sformatf("t3.dp%0d", k), 1'b1, 4'd10, 32'hD0 + 32'(k));
    end
    idle();
    step();
    rf("t3.ls0", 1'b1, 4'd8, 32'h800);
    step();
    rf("t3.ls1", 1'b1, 4'd9, 32'h900);
    step();
    check("t3.drained", 32'(bus.RF_WE), 32'd0);

    // WAW kill of a queued entry
    ls(1'b0, 4'd0, 32'h0, 1'b1, 4'd5, 32'h55);
    step();
    idle();
    dp(4'd5, 32'hDD);
    step();
    idle();
    bus.FWD_Addr = 4'd5;
    #1;
    rf("t3.kill_dp", 1'b1, 4'd5, 32'hDD);
    check("t3.kill_fwd", bus.FWD_data, 32'hDD);
    step();
    rf("t3.kill_pop", 1'b0, 4'd5, 32'hDD);

    // WAW kill of an entry pushed on the same edge
    ls(1'b0, 4'd0, 32'h0, 1'b1, 4'd6, 32'h66);
    dp(4'd6, 32'h77);
    step();
    idle();
    rf("t3.samecyc_dp", 1'b1, 4'd6, 32'h77);
    step();
    rf("t3.samecyc_pop", 1'b0, 4'd6, 32'h77);
    step();

    // fill under DP: stall threshold and overflow
    for (int k = 0; k < 5; k++) begin
      ls(1'b1, 4'd11, 32'h1000 + 32'(k), 1'b1, 4'd12, 32'h2000 + 32'(k));
      dp(4'd0, 32'h0);
      step();
      case (k)
        0: check("t4.stall_c2", 32'(bus.STALL), 32'd0);
        1: check("t4.stall_c4", 32'(bus.STALL), 32'd1);
        3: check("t4.ovf_c8", 32'(bus.OVF), 32'd0);
        4: check("t4.ovf_set", 32'(bus.OVF), 32'd1);
        default: check("t4.stall_c6", 32'(bus.STALL), 32'd1);
      endcase
    end
    idle();
    for (int k = 0; k < 4; k++) begin
      step();
      rf($sformatf("t4.drain_wb%0d", k), 1'b1, 4'd11, 32'h1000 + 32'(k));
      step();
      rf($sformatf("t4.drain_l%0d", k), 1'b1, 4'd12, 32'h2000 + 32'(k));
    end
    step();
    check("t4.lost", 32'(bus.RF_WE), 32'd0);
    check("t4.ovf_sticky", 32'(bus.OVF), 32'd1);
    check("t4.stall_empty", 32'(bus.STALL), 32'd0);

    // forwarding picks the newest pending value
    dp(4'd0, 32'h0);
    ls(1'b0, 4'd0, 32'h0, 1'b1, 4'd7, 32'h10);
    step();
    ls(1'b0, 4'd0, 32'h0, 1'b1, 4'd7, 32'h20);
    step();
    idle();
    bus.FWD_Addr = 4'd7;
    #1;
    check("t5.hit", 32'(bus.FWD_HIT), 32'd1);
    check("t5.newest", bus.FWD_data, 32'h20);
    step();
    check("t5.after_pop1", bus.FWD_data, 32'h20);
    step();
    rf("t5.write2", 1'b1, 4'd7, 32'h20);
    check("t5.rf_fwd", bus.FWD_data, 32'h20);
    step();
    check("t5.miss", 32'(bus.FWD_HIT), 32'd0);
    check("t5.miss_data", bus.FWD_data, 32'h0);

    // reset with entries queued discards them
    for (int k = 0; k < 2; k++) begin
      ls(1'b1, 4'd13, 32'h3000 + 32'(k), 1'b1, 4'd14, 32'h4000 + 32'(k));
      dp(4'd0, 32'h0);
      step();
    end
    check("t6.stall_before", 32'(bus.STALL), 32'd1);
    idle();
    rst = 1'b0;
    step();
    rf("t6.reset", 1'b0, 4'd0, 32'h0);
    check("t6.stall", 32'(bus.STALL), 32'd0);
    check("t6.ovf", 32'(bus.OVF), 32'd0);
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("t6.no_stale%0d", k), 32'(bus.RF_WE), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
